cdc_4phase_core: RTL and testbench

Clock-domain-crossing channel for one valid/ready stream. It uses a four-phase (return-to-zero) req/ack handshake, and each side synchronises the other side's control line through two flops. Each transfer carries one data word from the source domain to the destination domain. The block sits between two independently clocked subsystems. Throughput is low, but the crossing is glitch-free and safe against metastability.

---
 rtl/cdc_4phase_core.sv | 146 ++++++++++++++
 tb/tb_cdc_4phase_core.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_4phase_core.sv
// Four-phase req/ack clock-domain crossing for a single valid/ready stream.
// data_q is held stable while req or the synchronised ack is high, so only the
// req and ack control lines pass through two-flop synchronisers.
module cdc_4phase_core #(
  parameter int unsigned           DATA_WIDTH     = 64,
  parameter bit                    DECOUPLED      = 1'b0,
  parameter bit                    SEND_RESET_MSG = 1'b0,
  parameter logic [DATA_WIDTH-1:0] RESET_MSG      = '0
) (
  input  logic                  src_clk_i,
  input  logic                  src_rst_ni,
  input  logic                  dst_clk_i,
  input  logic                  dst_rst_ni,
  input  logic [DATA_WIDTH-1:0] src_data_i,
  input  logic                  src_valid_i,
  output logic                  src_ready_o,
  output logic [DATA_WIDTH-1:0] dst_data_o,
  output logic                  dst_valid_o,
  input  logic                  dst_ready_i
);

  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WAIT_ACK_HI = 2'd1,
    S_WAIT_ACK_LO = 2'd2
  } src_state_e;

  typedef enum logic {
    D_IDLE        = 1'b0,
    D_WAIT_REQ_LO = 1'b1
  } dst_state_e;

  src_state_e             src_state_q;
  logic                   req_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_s;

  dst_state_e             dst_state_q;
  logic                   ack_q;
  logic [SYNC_STAGES-1:0] req_sync_q;
  logic                   req_d;
  logic                   out_valid_q;
  logic [DATA_WIDTH-1:0]  out_data_q;

  assign ack_s = ack_sync_q[SYNC_STAGES-1];
  assign req_d = req_sync_q[SYNC_STAGES-1];

  // ack synchroniser into the source domain
  always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
    if (!src_rst_ni) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_q};
    end
  end

  // source FSM: capture word, raise req, wait for full ack round trip
  always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
    if (!src_rst_ni) begin
      src_state_q <= SEND_RESET_MSG ? S_WAIT_ACK_HI : S_IDLE;
      req_q       <= SEND_RESET_MSG;
      src_ready_o <= ~SEND_RESET_MSG;
      data_q      <= RESET_MSG;
    end else begin
      case (src_state_q)
        S_IDLE: begin
          if (src_valid_i) begin
            data_q      <= src_data_i;
            req_q       <= 1'b1;
            src_ready_o <= 1'b0;
            src_state_q <= S_WAIT_ACK_HI;
          end
        end
        S_WAIT_ACK_HI: begin
          if (ack_s) begin
            req_q       <= 1'b0;
            src_state_q <= S_WAIT_ACK_LO;
          end
        end
        S_WAIT_ACK_LO: begin
          if (!ack_s) begin
            src_ready_o <= 1'b1;
            src_state_q <= S_IDLE;
          end
        end
        default: begin
          req_q       <= 1'b0;
          src_ready_o <= 1'b1;
          src_state_q <= S_IDLE;
        end
      endcase
    end
  end

  // req synchroniser into the destination domain
  always_ff @(posedge dst_clk_i or negedge dst_rst_ni) begin
    if (!dst_rst_ni) begin
      req_sync_q <= '0;
    end else begin
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req_q};
    end
  end

  // destination FSM: acknowledge once the word is consumed (or registered)
  always_ff @(posedge dst_clk_i or negedge dst_rst_ni) begin
    if (!dst_rst_ni) begin
      dst_state_q <= D_IDLE;
      ack_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= RESET_MSG;
    end else begin
      if (DECOUPLED && dst_ready_i) begin
        out_valid_q <= 1'b0;
      end
      case (dst_state_q)
        D_IDLE: begin
          if (DECOUPLED) begin
            if (req_d && (!out_valid_q || dst_ready_i)) begin
              out_valid_q <= 1'b1;
              out_data_q  <= data_q;
              ack_q       <= 1'b1;
              dst_state_q <= D_WAIT_REQ_LO;
            end
          end else if (req_d && dst_ready_i) begin
            ack_q       <= 1'b1;
            dst_state_q <= D_WAIT_REQ_LO;
          end
        end
        D_WAIT_REQ_LO: begin
          if (!req_d) begin
            ack_q       <= 1'b0;
            dst_state_q <= D_IDLE;
          end
        end
      endcase
    end
  end

  // coupled mode presents the crossing register directly while req is seen
  assign dst_valid_o = DECOUPLED ? out_valid_q : (req_d && (dst_state_q == D_IDLE));
  assign dst_data_o  = DECOUPLED ? out_data_q  : data_q;

endmodule

// File: tb/tb_cdc_4phase_core.sv
// Randomised bench for cdc_4phase_core: three instances (coupled, decoupled,
// reset-message) checked against an in-order word scoreboard.
module tb_cdc_4phase_core;

  localparam int unsigned DW = 64;
  localparam int unsigned NI = 3;
  localparam logic [DW-1:0] RST_MSG = 64'hDEADBEEF;

  logic src_clk = 1'b0;
  logic dst_clk = 1'b0;
  logic src_rst_n;
  logic dst_rst_n;
  logic [NI-1:0]         src_valid;
  logic [NI-1:0]         src_ready;
  logic [NI-1:0]         dst_valid;
  logic [NI-1:0]         dst_ready = '0;
  logic [NI-1:0][DW-1:0] src_data;
  logic [NI-1:0][DW-1:0] dst_data;

  int checks = 0;
  int errors = 0;
  int dst_mode [NI];              // 0 stall, 1 always ready, 2 random
  logic [DW-1:0] exp_mem [NI][64];
  int wr_ptr [NI];
  int rd_ptr [NI];
  int beats  [NI];
  logic [DW-1:0] last_data [NI];
  bit rst_msg_queued = 1'b0;

  always #5 src_clk = ~src_clk;
  always #8 dst_clk = ~dst_clk;

  cdc_4phase_core #(.DATA_WIDTH(DW), .DECOUPLED(1'b0), .SEND_RESET_MSG(1'b0), .RESET_MSG('0)) u_dut0 (
    .src_clk_i(src_clk), .src_rst_ni(src_rst_n), .dst_clk_i(dst_clk), .dst_rst_ni(dst_rst_n),
    .src_data_i(src_data[0]), .src_valid_i(src_valid[0]), .src_ready_o(src_ready[0]),
    .dst_data_o(dst_data[0]), .dst_valid_o(dst_valid[0]), .dst_ready_i(dst_ready[0]));

  cdc_4phase_core #(.DATA_WIDTH(DW), .DECOUPLED(1'b1), .SEND_RESET_MSG(1'b0), .RESET_MSG('0)) u_dut1 (
    .src_clk_i(src_clk), .src_rst_ni(src_rst_n), .dst_clk_i(dst_clk), .dst_rst_ni(dst_rst_n),
    .src_data_i(src_data[1]), .src_valid_i(src_valid[1]), .src_ready_o(src_ready[1]),
    .dst_data_o(dst_data[1]), .dst_valid_o(dst_valid[1]), .dst_ready_i(dst_ready[1]));

  cdc_4phase_core #(.DATA_WIDTH(DW), .DECOUPLED(1'b0), .SEND_RESET_MSG(1'b1), .RESET_MSG(RST_MSG)) u_dut2 (
    .src_clk_i(src_clk), .src_rst_ni(src_rst_n), .dst_clk_i(dst_clk), .dst_rst_ni(dst_rst_n),
    .src_data_i(src_data[2]), .src_valid_i(src_valid[2]), .src_ready_o(src_ready[2]),
    .dst_data_o(dst_data[2]), .dst_valid_o(dst_valid[2]), .dst_ready_i(dst_ready[2]));

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference model, source side: every accepted beat (plus the reset message) enters the queue
  always @(negedge src_clk) begin
    if (src_rst_n && !rst_msg_queued) begin
      exp_mem[2][0]  = RST_MSG;
      wr_ptr[2]      = 1;
      rst_msg_queued = 1'b1;
    end
    for (int i = 0; i < NI; i++) begin
      if (src_rst_n && src_valid[i] && src_ready[i]) begin
        exp_mem[i][wr_ptr[i][5:0]] = src_data[i];
        wr_ptr[i]++;
      end
    end
  end

  // reference model, destination side: each beat must be the oldest outstanding word
  always @(negedge dst_clk) begin
    for (int i = 0; i < NI; i++) begin
      if (dst_rst_n && dst_valid[i] && dst_ready[i]) begin
        beats[i]++;
        last_data[i] = dst_data[i];
        chk($sformatf("d%0d_beat_expected", i), DW'(rd_ptr[i] != wr_ptr[i]), 64'd1);
        if (rd_ptr[i] != wr_ptr[i]) begin
          chk($sformatf("d%0d_beat_data", i), dst_data[i], exp_mem[i][rd_ptr[i][5:0]]);
          rd_ptr[i]++;
        end
      end
    end
  end

  // destination ready pattern per instance
  always @(posedge dst_clk) begin
    #1;
    for (int i = 0; i < NI; i++) begin
      case (dst_mode[i])
        0:       dst_ready[i] = 1'b0;
        1:       dst_ready[i] = 1'b1;
        default: dst_ready[i] = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic send(input int i, input logic [DW-1:0] d);
    bit taken;
    taken = 1'b0;
    @(posedge src_clk); #1;
    src_valid[i] = 1'b1;
    src_data[i]  = d;
    for (int c = 0; c < 500 && !taken; c++) begin
      @(negedge src_clk);
      taken = src_ready[i];
    end
    chk($sformatf("s%0d_accept", i), DW'(taken), 64'd1);
    @(posedge src_clk); #1;
    src_valid[i] = 1'b0;
    src_data[i]  = {$urandom, $urandom};
    @(negedge src_clk);
    chk($sformatf("s%0d_ready_fall", i), DW'(src_ready[i]), 64'd0);
  endtask

  task automatic wait_ready(input int i, input string tag);
    bit seen;
    seen = src_ready[i];
    for (int c = 0; c < 500 && !seen; c++) begin
      @(negedge src_clk);
      seen = src_ready[i];
    end
    chk(tag, DW'(seen), 64'd1);
  endtask

  task automatic wait_drain(input int i, input string tag);
    for (int c = 0; c < 3000 && rd_ptr[i] != wr_ptr[i]; c++) @(negedge dst_clk);
    chk(tag, DW'(rd_ptr[i] == wr_ptr[i]), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    logic [DW-1:0] word;
    src_rst_n = 1'b0;
    dst_rst_n = 1'b0;
    src_valid = '0;
    src_data  = '0;
    for (int i = 0; i < NI; i++) dst_mode[i] = 1;

    // values under reset
    repeat (4) @(negedge dst_clk);
    for (int i = 0; i < 2; i++) chk($sformatf("s%0d_rst_ready", i), DW'(src_ready[i]), 64'd1);
    for (int i = 0; i < NI; i++) chk($sformatf("d%0d_rst_valid", i), DW'(dst_valid[i]), 64'd0);

    @(posedge src_clk); #1;
    src_rst_n = 1'b1;
    dst_rst_n = 1'b1;
    @(negedge src_clk);
    chk("s2_rstmsg_busy", DW'(src_ready[2]), 64'd0);
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("s%0d_idle_ready", i), DW'(src_ready[i]), 64'd1);
        chk($sformatf("d%0d_idle_valid", i), DW'(dst_valid[i]), 64'd0);
      end
      @(negedge src_clk);
    end

    // reset message delivered before the source frees up, then user data follows
    wait_ready(2, "s2_rstmsg_done");
    chk("s2_rstmsg_beats", DW'(beats[2]), 64'd1);
    chk("s2_rstmsg_data", last_data[2], RST_MSG);
    send(2, 64'hA5A5_0001);
    wait_drain(2, "s2_user_drain");
    chk("s2_user_beats", DW'(beats[2]), 64'd2);

    // single beat
    b = beats[0];
    send(0, 64'h12345678);
    wait_ready(0, "s0_single_done");
    chk("s0_single_beats", DW'(beats[0] - b), 64'd1);
    chk("s0_single_data", last_data[0], 64'h0000000012345678);
    repeat (200) @(negedge src_clk);
    chk("s0_single_no_dup", DW'(beats[0] - b), 64'd1);
    chk("s0_single_valid_low", DW'(dst_valid[0]), 64'd0);

    // backpressure: word held stable while dst stalls
    dst_mode[0] = 0;
    word = {$urandom, $urandom};
    b = beats[0];
    send(0, word);
    for (int c = 0; c < 40 && !dst_valid[0]; c++) @(negedge dst_clk);
    chk("s0_bp_valid_rise", DW'(dst_valid[0]), 64'd1);
    repeat (20) begin
      @(negedge dst_clk);
      chk("s0_bp_valid_held", DW'(dst_valid[0]), 64'd1);
      chk("s0_bp_data_held", dst_data[0], word);
      chk("s0_bp_src_busy", DW'(src_ready[0]), 64'd0);
    end
    chk("s0_bp_no_beat", DW'(beats[0] - b), 64'd0);
    dst_mode[0] = 1;
    wait_ready(0, "s0_bp_done");
    chk("s0_bp_beats", DW'(beats[0] - b), 64'd1);

    // back-to-back stream with random ready
    dst_mode[0] = 2;
    b = beats[0];
    for (int k = 0; k < 8; k++) send(0, DW'(k));
    wait_drain(0, "s0_stream_drain");
    chk("s0_stream_beats", DW'(beats[0] - b), 64'd8);
    chk("s0_stream_last", last_data[0], 64'd7);

    // decoupled: ack completes while dst_ready is held low
    dst_mode[1] = 0;
    word = {$urandom, $urandom};
    b = beats[1];
    send(1, word);
    wait_ready(1, "s1_ack_without_ready");
    chk("s1_held_no_beat", DW'(beats[1] - b), 64'd0);
    chk("s1_held_valid", DW'(dst_valid[1]), 64'd1);
    chk("s1_held_data", dst_data[1], word);
    dst_mode[1] = 1;
    wait_drain(1, "s1_held_drain");
    chk("s1_held_beats", DW'(beats[1] - b), 64'd1);

    // decoupled stream with random ready
    dst_mode[1] = 2;
    b = beats[1];
    for (int k = 0; k < 8; k++) send(1, DW'(k));
    wait_drain(1, "s1_stream_drain");
    repeat (20) @(negedge dst_clk);
    chk("s1_stream_beats", DW'(beats[1] - b), 64'd8);
    chk("s1_stream_last", last_data[1], 64'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
